tt_scanner: RTL



---
 rtl/tt_pkg.sv | 14 +
 rtl/tt_settle_timer.sv | 28 ++
 rtl/tt_scanner.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the tt_scanner truth-table scanner.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam int unsigned N_MINTERMS  = 4;
  localparam int unsigned TIMER_W     = 4;
  localparam logic [3:0]  F5_EXPECTED = 4'b0010;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: 4-bit down-counter with load; o_tc flags the sample cycle.
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_tc
);

  logic [TIMER_W-1:0] r_cnt;

  // Load wins over counting; the count parks at zero until reloaded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TIMER_W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/tt_scanner.sv
// Truth-table scanner for a 2-input gate: drives (a,b) through minterms
// 0..3, samples s after SETTLE cycles each, and compares the captured table
// with EXPECTED. Optional macro TT_SCANNER_AUTORUN_EN makes scans repeat
// back-to-back after the first start until reset.
module tt_scanner
  import tt_pkg::*;
#(
  parameter logic [N_MINTERMS-1:0] EXPECTED = F5_EXPECTED,
  parameter int unsigned           SETTLE   = 1
)
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_a,
  output logic                  o_b,
  input  logic                  i_s,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [N_MINTERMS-1:0] o_table,
  output logic [N_MINTERMS-1:0] o_mismatch,
  output logic                  o_pass
);

  // Down-counter reload so the terminal count lands SETTLE cycles after load.
  localparam logic [TIMER_W-1:0] LP_RELOAD = TIMER_W'(SETTLE - 1);
  localparam logic [1:0]         LP_LAST_M = 2'(N_MINTERMS - 1);

  state_t                r_state;
  logic [1:0]            r_m;
  logic                  r_a;
  logic                  r_b;
  logic                  r_busy;
  logic                  r_done;
  logic [N_MINTERMS-1:0] r_table;
  logic [N_MINTERMS-1:0] r_mismatch;
  logic                  r_pass;

  state_t                w_state_nxt;
  logic [1:0]            w_m_nxt;
  logic [1:0]            w_m_inc;
  logic                  w_a_nxt;
  logic                  w_b_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic [N_MINTERMS-1:0] w_table_nxt;
  logic [N_MINTERMS-1:0] w_mismatch_nxt;
  logic                  w_pass_nxt;
  logic                  w_load;
  logic                  w_en;
  logic                  w_tc;

  assign w_m_inc = r_m + 2'd1;

  tt_settle_timer u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (LP_RELOAD),
    .i_en       (w_en),
    .o_tc       (w_tc)
  );

  // Register the state and every output; reset aborts any scan in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_m        <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_table    <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_m        <= w_m_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_table    <= w_table_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  // Next-state and next-output logic for the scan sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_m_nxt        = r_m;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_table_nxt    = r_table;
    w_mismatch_nxt = r_mismatch;
    w_pass_nxt     = r_pass;
    w_load         = 1'b0;
    w_en           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_m_nxt        = '0;
          w_a_nxt        = 1'b0;
          w_b_nxt        = 1'b0;
          w_table_nxt    = '0;
          w_mismatch_nxt = '0;
          w_pass_nxt     = 1'b0;
          w_busy_nxt     = 1'b1;
          w_load         = 1'b1;
          w_state_nxt    = DRIVE;
        end
      end
      DRIVE: begin
        w_en = 1'b1;
        if (w_tc) begin
          w_table_nxt[r_m] = i_s;
          if (r_m != LP_LAST_M) begin
            w_m_nxt            = w_m_inc;
            {w_a_nxt, w_b_nxt} = w_m_inc;
            w_load             = 1'b1;
          end else begin
            // Compare against the table including the bit captured this edge.
            w_mismatch_nxt = w_table_nxt ^ EXPECTED;
            w_pass_nxt     = (w_mismatch_nxt == '0);
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
            w_a_nxt        = 1'b0;
            w_b_nxt        = 1'b0;
            w_state_nxt    = DONE;
          end
        end
      end
      DONE: begin
`ifdef TT_SCANNER_AUTORUN_EN
        // Restart immediately; mismatch/pass keep the last result meanwhile.
        w_m_nxt     = '0;
        w_table_nxt = '0;
        w_busy_nxt  = 1'b1;
        w_load      = 1'b1;
        w_state_nxt = DRIVE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_table    = r_table;
  assign o_mismatch = r_mismatch;
  assign o_pass     = r_pass;

endmodule
